mod_addsub_sched: RTL and testbench

- Sequencer and arbiter for the modular adder/subtractor datapath.
- Accepts modular add/sub requests from two requesters and grants them round-robin.
- Per request: forms the raw sum or difference, then drives the correction-select vector for the second-stage mux bank.
- Returns (a op b) mod M to the granted requester over a valid/ready response channel.

---
 rtl/mod_addsub_sched_pkg.sv | 17 +
 rtl/mod_addsub_sched_if.sv | 29 ++
 rtl/mod_addsub_sched_rr_arb2.sv | 28 ++
 rtl/mod_addsub_sched.sv | 148 ++++++++++++++
 tb/tb_mod_addsub_sched.sv | 220 ++++++++++++++++++++++
 5 files changed

// File: rtl/mod_addsub_sched_pkg.sv
// Shared types and defaults for the modular add/sub scheduler.
package mod_addsub_pkg;

    localparam int W_DEF = 4;
    localparam int M_DEF = 12;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        CORR = 2'd2,
        RESP = 2'd3
    } state_t;

endpackage

// File: rtl/mod_addsub_sched_if.sv
// Request/response bundle between the requesters/consumer and mod_addsub_sched.
interface mod_addsub_sched_if
    import mod_addsub_pkg::*;
#(
    parameter int W = W_DEF
);
    logic [1:0]     req_valid;
    logic [1:0]     req_ready;
    logic [1:0]     req_op;
    logic [2*W-1:0] req_a;
    logic [2*W-1:0] req_b;
    logic           rsp_valid;
    logic           rsp_ready;
    logic           rsp_id;
    logic [W-1:0]   rsp_data;
    logic           rsp_err;
    logic [W-1:0]   corr_sel;
    logic           busy;

    modport master (
        output req_valid, req_op, req_a, req_b, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_data, rsp_err, corr_sel, busy
    );

    modport slave (
        input  req_valid, req_op, req_a, req_b, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_data, rsp_err, corr_sel, busy
    );
endinterface

// File: rtl/mod_addsub_sched_rr_arb2.sv
// Two-input round-robin arbiter; last-grant pointer resets to 1 so input 0 wins first.
module rr_arb2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] grant
);
    logic last_reg;

    always_comb begin
        grant = 2'b00;
        case (req)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = last_reg ? 2'b01 : 2'b10;
            default: grant = 2'b00;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_reg <= 1'b1;
        end else if (advance) begin
            last_reg <= grant[1];
        end
    end
endmodule

// File: rtl/mod_addsub_sched.sv
// Round-robin sequencer for the modular adder/subtractor: arbitrate, raw op, correct, respond.
// Optional operand range check is enabled by defining MOD_RANGE_CHECK_EN.
module mod_addsub_sched
    import mod_addsub_pkg::*;
#(
    parameter int W = W_DEF,
    parameter int M = M_DEF
)(
    input  logic              clk,
    input  logic              rst_n,
    mod_addsub_sched_if.slave bus
);
    localparam logic [W:0]   M_X = M[W:0];
    localparam logic [W-1:0] M_W = M[W-1:0];

    state_t         state_reg;
    logic           op_reg;
    logic [W-1:0]   a_reg;
    logic [W-1:0]   b_reg;
    logic           id_reg;
    logic [W:0]     raw_reg;
    logic           rsp_valid_reg;
    logic           rsp_id_reg;
    logic [W-1:0]   rsp_data_reg;
    logic [W-1:0]   corr_sel_reg;
    logic           busy_reg;

    logic [W-1:0]   a_sl [2];
    logic [W-1:0]   b_sl [2];
    logic [1:0]     grant;
    logic           accept;
    logic           sel_id;
    logic [W:0]     raw_next;
    logic           corrected;
    logic [W-1:0]   result;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_unpack
            assign a_sl[gi] = bus.req_a[gi*W +: W];
            assign b_sl[gi] = bus.req_b[gi*W +: W];
        end
    endgenerate

    rr_arb2 u_arb (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (bus.req_valid),
        .advance (accept),
        .grant   (grant)
    );

    // req_ready is only offered in IDLE and is forced low while reset is held.
    assign bus.req_ready = (state_reg == IDLE && rst_n) ? grant : 2'b00;
    assign accept        = |(bus.req_valid & bus.req_ready);
    assign sel_id        = grant[1];

    assign raw_next = (op_reg == OP_SUB) ? ({1'b0, a_reg} - {1'b0, b_reg})
                                         : ({1'b0, a_reg} + {1'b0, b_reg});

    // Subtract wraps below zero (borrow); add overflows at or above M.
    always_comb begin
        corrected = (op_reg == OP_SUB) ? raw_reg[W] : (raw_reg >= M_X);
        result    = raw_reg[W-1:0];
        if (corrected) begin
            result = (op_reg == OP_SUB) ? raw_reg[W-1:0] + M_W : raw_reg[W-1:0] - M_W;
        end
    end

`ifdef MOD_RANGE_CHECK_EN
    logic rsp_err_reg;
    assign bus.rsp_err = rsp_err_reg;
`else
    assign bus.rsp_err = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            op_reg        <= OP_ADD;
            a_reg         <= '0;
            b_reg         <= '0;
            id_reg        <= 1'b0;
            raw_reg       <= '0;
            rsp_valid_reg <= 1'b0;
            rsp_id_reg    <= 1'b0;
            rsp_data_reg  <= '0;
            corr_sel_reg  <= '1;
            busy_reg      <= 1'b0;
`ifdef MOD_RANGE_CHECK_EN
            rsp_err_reg   <= 1'b0;
`endif
        end else begin
            case (state_reg)
                IDLE: begin
                    if (accept) begin
                        op_reg    <= bus.req_op[sel_id];
                        a_reg     <= a_sl[sel_id];
                        b_reg     <= b_sl[sel_id];
                        id_reg    <= sel_id;
                        busy_reg  <= 1'b1;
                        state_reg <= CALC;
                    end
                end
                CALC: begin
                    raw_reg <= raw_next;
`ifdef MOD_RANGE_CHECK_EN
                    if (a_reg >= M_W || b_reg >= M_W) begin
                        rsp_err_reg   <= 1'b1;
                        rsp_data_reg  <= '0;
                        rsp_id_reg    <= id_reg;
                        rsp_valid_reg <= 1'b1;
                        state_reg     <= RESP;
                    end else begin
                        state_reg <= CORR;
                    end
`else
                    state_reg <= CORR;
`endif
                end
                CORR: begin
                    rsp_data_reg  <= result;
                    corr_sel_reg  <= {W{~corrected}};
                    rsp_id_reg    <= id_reg;
                    rsp_valid_reg <= 1'b1;
`ifdef MOD_RANGE_CHECK_EN
                    rsp_err_reg   <= 1'b0;
`endif
                    state_reg     <= RESP;
                end
                RESP: begin
                    if (bus.rsp_ready) begin
                        rsp_valid_reg <= 1'b0;
                        busy_reg      <= 1'b0;
                        state_reg     <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign bus.rsp_valid = rsp_valid_reg;
    assign bus.rsp_id    = rsp_id_reg;
    assign bus.rsp_data  = rsp_data_reg;
    assign bus.corr_sel  = corr_sel_reg;
    assign bus.busy      = busy_reg;
endmodule

// File: tb/tb_mod_addsub_sched.sv
// Scoreboard bench for mod_addsub_sched (W=4, M=12); error case runs when MOD_RANGE_CHECK_EN is defined.
module tb_mod_addsub_sched;
    import mod_addsub_pkg::*;

    localparam int W = 4;

    typedef struct { int id; int op; int a; int b; int data; int cs; } vec_t;
    typedef struct { int id; int data; int cs; int err; int lat; } exp_t;
    typedef struct { logic op; logic [W-1:0] a; logic [W-1:0] b; } stim_t;

    logic  clk = 1'b0;
    logic  rst_n = 1'b0;
    int    tests = 0;
    int    fails = 0;
    int    cyc = 0;
    int    last_acc_cyc = 0;
    logic  acc0 = 1'b0;
    logic  acc1 = 1'b0;
    exp_t  sb[$];
    stim_t q0[$];
    stim_t q1[$];

    mod_addsub_sched_if #(.W(W)) bus();

    mod_addsub_sched #(.W(W), .M(12)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // One clock of requester driving; accepted items leave their queue.
    task automatic step();
        bus.req_valid = {q1.size() != 0, q0.size() != 0};
        bus.req_op = '0;
        bus.req_a  = '0;
        bus.req_b  = '0;
        if (q0.size() != 0) begin
            bus.req_op[0]   = q0[0].op;
            bus.req_a[0 +: W] = q0[0].a;
            bus.req_b[0 +: W] = q0[0].b;
        end
        if (q1.size() != 0) begin
            bus.req_op[1]   = q1[0].op;
            bus.req_a[W +: W] = q1[0].a;
            bus.req_b[W +: W] = q1[0].b;
        end
        @(negedge clk);
        acc0 = bus.req_valid[0] & bus.req_ready[0];
        acc1 = bus.req_valid[1] & bus.req_ready[1];
        if (acc0 || acc1) last_acc_cyc = cyc;
        @(posedge clk);
        #1;
        if (acc0) void'(q0.pop_front());
        if (acc1) void'(q1.pop_front());
    endtask

    task automatic issue(input int id, input int op, input int a, input int b,
                         input int data, input int cs, input int err, input int lat,
                         input bit expect_rsp);
        stim_t s;
        exp_t  e;
        s.op = op[0];
        s.a  = a[W-1:0];
        s.b  = b[W-1:0];
        if (id == 0) q0.push_back(s); else q1.push_back(s);
        if (expect_rsp) begin
            e.id = id; e.data = data; e.cs = cs; e.err = err; e.lat = lat;
            sb.push_back(e);
        end
    endtask

    task automatic drain(input string name, input int maxc);
        int n = 0;
        while ((q0.size() != 0 || q1.size() != 0 || sb.size() != 0) && n < maxc) begin
            step();
            n++;
        end
        chk(name, q0.size() + q1.size() + sb.size(), 0);
    endtask

    // Monitor: latency on each rsp_valid rise, full compare on each handshake.
    initial begin : monitor
        bit   prev_v;
        int   have;
        exp_t e;
        prev_v = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_v = 1'b0;
            end else begin
                if (bus.rsp_valid && !prev_v) begin
                    have = (sb.size() != 0) ? 1 : 0;
                    chk("rsp_expected", have, 1);
                    if (have != 0) chk("latency", cyc - last_acc_cyc, sb[0].lat);
                end
                if (bus.rsp_valid && bus.rsp_ready) begin
                    have = (sb.size() != 0) ? 1 : 0;
                    chk("hs_expected", have, 1);
                    if (have != 0) begin
                        e = sb.pop_front();
                        chk("rsp_id", int'(bus.rsp_id), e.id);
                        chk("rsp_data", int'(bus.rsp_data), e.data);
                        chk("corr_sel", int'(bus.corr_sel), e.cs);
                        chk("rsp_err", int'(bus.rsp_err), e.err);
                        $display("[TB] rsp id=%0d data=%0d corr_sel=%b err=%0d (exp id=%0d data=%0d)",
                                 bus.rsp_id, bus.rsp_data, bus.corr_sel, bus.rsp_err, e.id, e.data);
                    end
                end
                prev_v = bus.rsp_valid;
            end
        end
    end

    vec_t vecs[6] = '{
        '{0, 0,  7, 8,  3,  0},
        '{1, 1,  3, 5, 10,  0},
        '{0, 1,  9, 4,  5, 15},
        '{1, 0, 11, 1,  0,  0},
        '{0, 1,  5, 5,  0, 15},
        '{1, 0,  2, 3,  5, 15}
    };

    initial begin
        int n;
        bus.req_valid = '0;
        bus.req_op    = '0;
        bus.req_a     = '0;
        bus.req_b     = '0;
        bus.rsp_ready = 1'b1;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_rsp_valid", int'(bus.rsp_valid), 0);
        chk("rst_req_ready", int'(bus.req_ready), 0);
        chk("rst_busy", int'(bus.busy), 0);
        chk("rst_corr_sel", int'(bus.corr_sel), 15);
        chk("rst_rsp_data", int'(bus.rsp_data), 0);
        rst_n = 1'b1;

        // Directed single-request vectors.
        foreach (vecs[i]) begin
            issue(vecs[i].id, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].data, vecs[i].cs, 0, 3, 1'b1);
            drain("vec_drain", 40);
        end

        // Response back-pressure with a pending request on requester 1.
        bus.rsp_ready = 1'b0;
        issue(0, 0, 2, 3, 5, 15, 0, 3, 1'b1);
        n = 0;
        do begin step(); n++; end while (!acc0 && n < 10);
        chk("stall_accept0", int'(acc0), 1);
        issue(1, 0, 6, 6, 0, 0, 0, 3, 1'b1);
        n = 0;
        while (!bus.rsp_valid && n < 10) begin step(); n++; end
        chk("stall_reach_resp", int'(bus.rsp_valid), 1);
        for (int i = 0; i < 5; i++) begin
            step();
            chk("stall_acc1", int'(acc1), 0);
            chk("stall_req_ready", int'(bus.req_ready), 0);
            chk("stall_rsp_valid", int'(bus.rsp_valid), 1);
            chk("stall_rsp_data", int'(bus.rsp_data), 5);
            chk("stall_rsp_id", int'(bus.rsp_id), 0);
        end
        bus.rsp_ready = 1'b1;
        step();
        chk("hs_cycle_no_acc", int'(acc1), 0);
        step();
        chk("accept_after_hs", int'(acc1), 1);
        drain("stall_drain", 40);

        // Reset during CORR: no response, outputs cleared.
        issue(0, 0, 7, 8, 3, 0, 0, 3, 1'b0);
        n = 0;
        do begin step(); n++; end while (!acc0 && n < 10);
        chk("rst_test_accept", int'(acc0), 1);
        step();
        chk("busy_in_corr", int'(bus.busy), 1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_rsp_valid", int'(bus.rsp_valid), 0);
        chk("mid_rst_req_ready", int'(bus.req_ready), 0);
        chk("mid_rst_rsp_data", int'(bus.rsp_data), 0);
        chk("mid_rst_rsp_id", int'(bus.rsp_id), 0);
        chk("mid_rst_rsp_err", int'(bus.rsp_err), 0);
        chk("mid_rst_corr_sel", int'(bus.corr_sel), 15);
        chk("mid_rst_busy", int'(bus.busy), 0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (6) step();

        // Both requesters continuously valid: grants alternate 0,1,0,1.
        issue(0, 0, 11, 11, 10,  0, 0, 3, 1'b1);
        issue(1, 1,  0, 11,  1,  0, 0, 3, 1'b1);
        issue(0, 0,  2,  3,  5, 15, 0, 3, 1'b1);
        issue(1, 1,  5,  5,  0, 15, 0, 3, 1'b1);
        drain("rr_drain", 80);

`ifdef MOD_RANGE_CHECK_EN
        issue(0, 0, 13, 0, 0, 15, 1, 2, 1'b1);
        drain("err_drain", 40);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
